// File: rtl/conv_pkg.sv
// Shared types and address-map helpers for the conv job feeder.
package conv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_W,
    LOAD_P,
    DRAIN
  } feed_state_t;

  localparam int W_BASE = 0;

  // Pixels start right after the kernel weights in the job buffer
  function automatic int P_BASE(input int k);
    return k * k;
  endfunction

  function automatic int TOTAL_BEATS(input int d, input int k);
    return k * k + d * d;
  endfunction

endpackage

// File: rtl/feed_skid_buf.sv
// Two-entry {w_en, data} buffer with a registered head that drives the outgoing beat.
module feed_skid_buf #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  push_w_en,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            count,
  output logic                  head_valid,
  output logic                  head_w_en,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic                  tail_w_en;
  logic [DATA_WIDTH-1:0] tail_data;
  logic                  pop_ok;

  assign head_valid = (count != 2'd0);
  assign pop_ok     = pop & head_valid;

  // Incoming data lands in the head whenever the head slot is free after this cycle's pop
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= 2'd0;
      head_w_en <= 1'b0;
      head_data <= '0;
      tail_w_en <= 1'b0;
      tail_data <= '0;
    end else begin
      if (pop_ok && count == 2'd2) begin
        head_w_en <= tail_w_en;
        head_data <= tail_data;
      end
      if (push) begin
        if (count == 2'd0 || (count == 2'd1 && pop_ok)) begin
          head_w_en <= push_w_en;
          head_data <= push_data;
        end else begin
          tail_w_en <= push_w_en;
          tail_data <= push_data;
        end
      end
      count <= count + 2'(push) - 2'(pop_ok);
    end
  end

endmodule

// File: rtl/conv_feeder.sv
// Reads one conv job (weights then pixels) from the job buffer and streams it
// downstream over a valid/ready link, absorbing backpressure in a 2-entry skid buffer.
module conv_feeder
  import conv_pkg::*;
#(
  parameter int DATA_SIZE   = 32,
  parameter int KERNEL_SIZE = 5,
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_BW     = $clog2(KERNEL_SIZE*KERNEL_SIZE + DATA_SIZE*DATA_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_rd_en,
  output logic [ADDR_BW-1:0]    o_rd_addr,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_valid,
  output logic                  o_w_en,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready
);

  localparam int                 N_W         = P_BASE(KERNEL_SIZE);
  localparam int                 N_TOTAL     = TOTAL_BEATS(DATA_SIZE, KERNEL_SIZE);
  localparam logic [ADDR_BW-1:0] FIRST_ADDR  = ADDR_BW'(W_BASE);
  localparam logic [ADDR_BW-1:0] LAST_W_ADDR = ADDR_BW'(N_W - 1);
  localparam logic [ADDR_BW-1:0] LAST_ADDR   = ADDR_BW'(N_TOTAL - 1);

  feed_state_t          state;
  logic                 inflight;
  logic                 inflight_w_en;
  logic [ADDR_BW-1:0]   rd_addr;
  logic [ADDR_BW-1:0]   beat_cnt;
  logic [1:0]           buf_count;
  logic                 pop;
  logic [2:0]           occupancy;
  logic                 issue;

  // A read may only be issued if its data is guaranteed a slot in the skid buffer
  assign pop       = o_valid & i_ready;
  assign occupancy = {2'b00, inflight} + {1'b0, buf_count} - {2'b00, pop};
  assign issue     = (state == LOAD_W || state == LOAD_P) && (occupancy < 3'd2);
  assign o_rd_en   = issue;
  assign o_rd_addr = rd_addr;

  feed_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk        (clk),
    .rst        (rst),
    .push       (inflight),
    .push_w_en  (inflight_w_en),
    .push_data  (i_rd_data),
    .pop        (pop),
    .count      (buf_count),
    .head_valid (o_valid),
    .head_w_en  (o_w_en),
    .head_data  (o_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      rd_addr       <= '0;
      beat_cnt      <= '0;
      inflight      <= 1'b0;
      inflight_w_en <= 1'b0;
    end else begin
      o_done        <= 1'b0;
      inflight      <= issue;
      inflight_w_en <= (state == LOAD_W);
      if (issue) rd_addr <= rd_addr + 1'b1;
      if (pop) beat_cnt <= beat_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (i_start) begin
            state    <= LOAD_W;
            o_busy   <= 1'b1;
            rd_addr  <= FIRST_ADDR;
            beat_cnt <= '0;
          end
        end
        LOAD_W: if (issue && rd_addr == LAST_W_ADDR) state <= LOAD_P;
        LOAD_P: if (issue && rd_addr == LAST_ADDR) state <= DRAIN;
        DRAIN: begin
          if (pop && beat_cnt == LAST_ADDR) begin
            state  <= IDLE;
            o_busy <= 1'b0;
            o_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/conv_feeder.md
# conv_feeder

Streams one convolution job into the conv datapath: first the KERNEL_SIZE×KERNEL_SIZE weights tagged with `o_w_en`, then the DATA_SIZE×DATA_SIZE image pixels in raster order (row i, column j, j fastest). It is the transmit end of the valid/w_en pixel stream consumed by the conv control path, and the read end of the job buffer memory. Downstream backpressure (`i_ready`) is absorbed by a 2-entry skid buffer so that no beat is lost or duplicated.

## Interface
- DATA_SIZE, 32, image side length in pixels
- KERNEL_SIZE, 5, kernel side length
- DATA_WIDTH, 8, bits per pixel and per weight
- ADDR_BW, $clog2(KERNEL_SIZE*KERNEL_SIZE + DATA_SIZE*DATA_SIZE), job buffer address width
- clk  in  1  single clock, all logic on posedge
- rst  in  1  reset, synchronous, active-high
- i_start  in  1  start a job; sampled only in IDLE
- o_busy  out  1  job in progress
- o_done  out  1  one-cycle pulse after the final beat handshake
- o_rd_en  out  1  job buffer read strobe
- o_rd_addr  out  ADDR_BW  read address: weights at 0..K*K-1, pixels at K*K..K*K+D*D-1
- i_rd_data  in  DATA_WIDTH  read data, valid exactly 1 cycle after `o_rd_en`
- o_valid  out  1  beat present on `o_data`
- o_w_en  out  1  the current beat is a weight (1) or a pixel (0)
- o_data  out  DATA_WIDTH  beat payload
- i_ready  in  1  downstream accepts the beat; handshake = `o_valid & i_ready`

## Operation
- FSM states: IDLE, LOAD_W, LOAD_P, DRAIN.
  - IDLE → LOAD_W on `i_start`.
  - LOAD_W → LOAD_P after issuing read K*K-1.
  - LOAD_P → DRAIN after issuing read K*K+D*D-1.
  - DRAIN → IDLE on the handshake of the final beat; `o_done` is pulsed on entering IDLE.
- Read issue: in LOAD_W/LOAD_P, `o_rd_en`=1 iff (inflight + count − pop) < 2, where pop = `o_valid & i_ready`. Each issue increments the address counter by 1. The address counter resets to 0 on job start.
- The `w_en` tag for each issued read is 1 in LOAD_W and 0 in LOAD_P. It travels with the inflight bit and is stored alongside the data in the skid buffer.
- Skid buffer: 2 entries with a registered head. When empty, incoming read data goes straight to the head. The head drives `o_valid`/`o_data`/`o_w_en`.
- `o_data` and `o_w_en` hold stable while `o_valid & !i_ready`.
- `i_rd_data` is captured only in the cycle after `o_rd_en`; at all other times it is ignored.
- `i_start` is ignored while `o_busy`. A start arriving in the same cycle that `o_done` is high is accepted, because the FSM is already in IDLE.
- The beat counter and the address counter are ADDR_BW wide. They never wrap within a job and are cleared at job start.
- Reset values: FSM=IDLE; `o_busy`=0, `o_done`=0, `o_rd_en`=0, `o_rd_addr`=0, `o_valid`=0, `o_w_en`=0, `o_data`=0; inflight=0, count=0.
- Reset mid-job aborts immediately: the buffer is flushed and any read still in flight is discarded. No `o_done` is generated for an aborted job.

## Timing
- The cycle in which `i_start` is sampled is cycle 0. Then:
  - `o_busy`=1 and first `o_rd_en` (addr 0) in cycle 1.
  - First `o_valid` (`o_w_en`=1) in cycle 3.
- With `i_ready` held at 1: one beat per cycle. The final beat is in cycle 3+K*K+D*D−1 and `o_done` is in the next cycle.
- `o_busy` stays high from cycle 1 through the final handshake cycle and is low when `o_done` is high.
- When `i_ready` drops:
  - At most 2 beats are buffered.
  - Reads stall within 1 cycle.
  - Throughput resumes at 1 beat/cycle on the cycle after `i_ready` returns.

## Structure
- Shared package `conv_pkg` holds:
  - FSM state enum `feed_state_t`.
  - Address-map constants `W_BASE`=0 and `P_BASE`=K*K.
  - Beat-count function `TOTAL_BEATS`=K*K+D*D.
- Sub-module `feed_skid_buf`: 2-entry buffer of {w_en, data} with a push/pop interface and count output. The FSM, counters and credit logic stay in `conv_feeder`.

## Test plan
All scenarios use D=4, K=2 (20 beats) and memory model mem[a]=a.
- Start with `i_ready`=1:
  - Beats 0..19 carry data 0..19.
  - `o_w_en`=1 for beats 0..3 and 0 for the rest.
  - First `o_valid` in cycle 3, last in cycle 22, `o_done` in cycle 23.
- Hold `i_ready` low for cycles 5–9:
  - `o_data` stays frozen while `i_ready` is low.
  - No beat is lost or duplicated; sequence is still 0..19.
  - Never more than 2 reads are outstanding plus buffered.
  - `o_done` arrives 5 cycles later (cycle 28).
- Random `i_ready` (50% duty), 3 back-to-back jobs with `i_start` asserted in the `o_done` cycle:
  - Each job delivers exactly 20 beats in order.
  - Each job produces exactly one `o_done`.
- Pulse `i_start` at cycle 6 mid-job:
  - The pulse is ignored.
  - The job completes normally with 20 beats.
- Assert `rst` at cycle 10, then start again at cycle 12:
  - `o_valid`=0 and `o_busy`=0 in cycle 11.
  - No `o_done` for the aborted job.
  - The new job restarts at data 0 with `o_w_en`=1.
- Force `i_rd_data`=8'hFF in every cycle that is not a read-return cycle:
  - The stream still carries 0..19.
